// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, H/V position counters, registered sync/blank decode.
// Define VGA_FRAME_COUNT_EN to add the 16-bit frame_count output.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 2,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        pixel_tick,
    output logic [15:0] H_Counter_Value,
    output logic [15:0] V_Counter_Value,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
`ifdef VGA_FRAME_COUNT_EN
    output logic [15:0] frame_count,
`endif
    output logic        frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [15:0] H_LAST  = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST  = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_VIS   = 16'(H_VISIBLE);
    localparam logic [15:0] V_VIS   = 16'(V_VISIBLE);
    localparam logic [15:0] HS_LO   = 16'(H_VISIBLE + H_FRONT);
    localparam logic [15:0] HS_HI   = 16'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [15:0] VS_LO   = 16'(V_VISIBLE + V_FRONT);
    localparam logic [15:0] VS_HI   = 16'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div_reg, div_next;
    logic [15:0]      h_reg, h_next, v_reg, v_next;
    logic             tick_reg, tick_next;
    logic             fs_reg, fs_next;
    logic             hsync_reg, hsync_next;
    logic             vsync_reg, vsync_next;
    logic             video_reg, video_next;
    logic             step, h_wrap, v_wrap;

    always_comb begin
        step       = en && (div_reg == DIV_LAST);
        h_wrap     = (h_reg == H_LAST);
        v_wrap     = (v_reg == V_LAST);
        div_next   = div_reg;
        h_next     = h_reg;
        v_next     = v_reg;
        if (en) begin
            div_next = (div_reg == DIV_LAST) ? '0 : div_reg + DIV_W'(1);
        end
        if (step) begin
            if (h_wrap) begin
                h_next = '0;
                v_next = v_wrap ? '0 : v_reg + 16'd1;
            end else begin
                h_next = h_reg + 16'd1;
            end
        end
        // Decode from the next position so sync/blank move on the same edge as H/V.
        tick_next  = en && (div_next == DIV_LAST);
        fs_next    = step && h_wrap && v_wrap;
        hsync_next = ((h_next >= HS_LO) && (h_next <= HS_HI)) ? SYNC_POL : ~SYNC_POL;
        vsync_next = ((v_next >= VS_LO) && (v_next <= VS_HI)) ? SYNC_POL : ~SYNC_POL;
        video_next = (h_next < H_VIS) && (v_next < V_VIS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg   <= '0;
            h_reg     <= '0;
            v_reg     <= '0;
            tick_reg  <= 1'b0;
            fs_reg    <= 1'b0;
            hsync_reg <= ~SYNC_POL;
            vsync_reg <= ~SYNC_POL;
            video_reg <= 1'b1;
        end else begin
            div_reg   <= div_next;
            h_reg     <= h_next;
            v_reg     <= v_next;
            tick_reg  <= tick_next;
            fs_reg    <= fs_next;
            hsync_reg <= hsync_next;
            vsync_reg <= vsync_next;
            video_reg <= video_next;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count_reg <= '0;
        end else if (fs_next) begin
            frame_count_reg <= frame_count_reg + 16'd1;
        end
    end

    assign frame_count = frame_count_reg;
`endif

    assign pixel_tick      = tick_reg;
    assign frame_start     = fs_reg;
    assign H_Counter_Value = h_reg;
    assign V_Counter_Value = v_reg;
    assign hsync           = hsync_reg;
    assign vsync           = vsync_reg;
    assign video_on        = video_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: arithmetic raster model checked every cycle on three geometries,
// plus directed literal checks of reset, line decode, enable hold and asynchronous reset.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    always #5 clk = ~clk;

    int  vectors = 0;
    int  miscompares = 0;
    bit  chk_on = 1'b0;

    logic        a_tick, a_hs, a_vs, a_vid, a_fs;
    logic [15:0] a_h, a_v;
    logic        b_tick, b_hs, b_vs, b_vid, b_fs;
    logic [15:0] b_h, b_v;
    logic        c_tick, c_hs, c_vs, c_vid, c_fs;
    logic [15:0] c_h, c_v;
`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] a_fc, b_fc, c_fc;
`endif

    vga_timing_gen dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .pixel_tick(a_tick),
        .H_Counter_Value(a_h), .V_Counter_Value(a_v),
        .hsync(a_hs), .vsync(a_vs), .video_on(a_vid),
`ifdef VGA_FRAME_COUNT_EN
        .frame_count(a_fc),
`endif
        .frame_start(a_fs)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .CLK_DIV(3), .SYNC_POL(1'b1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .pixel_tick(b_tick),
        .H_Counter_Value(b_h), .V_Counter_Value(b_v),
        .hsync(b_hs), .vsync(b_vs), .video_on(b_vid),
`ifdef VGA_FRAME_COUNT_EN
        .frame_count(b_fc),
`endif
        .frame_start(b_fs)
    );

    vga_timing_gen #(
        .H_VISIBLE(5), .H_FRONT(1), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
        .CLK_DIV(1), .SYNC_POL(1'b0)
    ) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .pixel_tick(c_tick),
        .H_Counter_Value(c_h), .V_Counter_Value(c_v),
        .hsync(c_hs), .vsync(c_vs), .video_on(c_vid),
`ifdef VGA_FRAME_COUNT_EN
        .frame_count(c_fc),
`endif
        .frame_start(c_fs)
    );

    // Model state: number of enabled clock edges since reset, and whether the last edge was enabled.
    int n_en;
    bit en_last;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_en    <= 0;
            en_last <= 1'b0;
        end else begin
            en_last <= en;
            if (en) n_en <= n_en + 1;
        end
    end

    // Raster position is simply (enabled edges / CLK_DIV) pixels into an endless scan.
    function automatic logic [36:0] model_out(int n, bit el, int hv, int hf, int hs, int hb,
                                              int vv, int vf, int vs, int vb, int cd, bit pol);
        int ht, vt, p, d, h, v;
        logic tick, fs, hsy, vsy, vid;
        ht   = hv + hf + hs + hb;
        vt   = vv + vf + vs + vb;
        p    = n / cd;
        d    = n % cd;
        h    = p % ht;
        v    = (p / ht) % vt;
        tick = el && (d == cd - 1);
        fs   = el && (d == 0) && (p > 0) && ((p % (ht * vt)) == 0);
        hsy  = (h >= hv + hf && h < hv + hf + hs) ? pol : !pol;
        vsy  = (v >= vv + vf && v < vv + vf + vs) ? pol : !pol;
        vid  = (h < hv) && (v < vv);
        return {tick, fs, hsy, vsy, vid, 16'(h), 16'(v)};
    endfunction

    task automatic cmp(string nm, logic [36:0] got, logic [36:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s n=%0d got tick/fs/hs/vs/vid=%b h=%0d v=%0d, expected %b h=%0d v=%0d",
                     nm, n_en, got[36:32], got[31:16], got[15:0], exp[36:32], exp[31:16], exp[15:0]);
        end
    endtask

    task automatic chk(string nm, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("model_a", {a_tick, a_fs, a_hs, a_vs, a_vid, a_h, a_v},
                model_out(n_en, en_last, 640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0));
            cmp("model_b", {b_tick, b_fs, b_hs, b_vs, b_vid, b_h, b_v},
                model_out(n_en, en_last, 8, 2, 3, 2, 6, 1, 2, 2, 3, 1'b1));
            cmp("model_c", {c_tick, c_fs, c_hs, c_vs, c_vid, c_h, c_v},
                model_out(n_en, en_last, 5, 1, 2, 2, 4, 1, 1, 2, 1, 1'b0));
`ifdef VGA_FRAME_COUNT_EN
            chk("fcount_a", int'(a_fc), (n_en / 2 / 420000) % 65536);
            chk("fcount_b", int'(b_fc), (n_en / 3 / 165) % 65536);
            chk("fcount_c", int'(c_fc), (n_en / 80) % 65536);
`endif
        end
    end

    // Line-0 statistics of the default-geometry instance, one sample per pixel tick.
    int line_ticks = 0, hs_cnt = 0, vid_cnt = 0, hs_min = 65535, hs_max = -1;
    int b_first = -1, c_first = -1;
    always @(negedge clk) begin
        if (chk_on && rst_n) begin
            if (a_tick && a_v == 16'd0) begin
                line_ticks++;
                if (!a_hs) begin
                    hs_cnt++;
                    if (int'(a_h) < hs_min) hs_min = int'(a_h);
                    if (int'(a_h) > hs_max) hs_max = int'(a_h);
                end
                if (a_vid) vid_cnt++;
            end
            if (b_fs && b_first < 0) b_first = n_en;
            if (c_fs && c_first < 0) c_first = n_en;
        end
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_h", int'(a_h), 0);
        chk("rst_v", int'(a_v), 0);
        chk("rst_hsync", int'(a_hs), 1);
        chk("rst_vsync", int'(a_vs), 1);
        chk("rst_video", int'(a_vid), 1);
        chk("rst_tick", int'(a_tick), 0);
        chk("rst_fs", int'(a_fs), 0);
        chk("rst_b_hsync", int'(b_hs), 0);
        chk("rst_b_vsync", int'(b_vs), 0);

        chk_on = 1'b1;
        rst_n  = 1'b1;
        for (int k = 1; k <= 690; k++) begin
            @(negedge clk);
            #1;
            if (k == 1) begin
                chk("k1_tick", int'(a_tick), 1);
                chk("k1_h", int'(a_h), 0);
            end
            if (k == 2) begin
                chk("k2_tick", int'(a_tick), 0);
                chk("k2_h", int'(a_h), 1);
            end
        end
        chk("pre_hold_h", int'(a_h), 345);
        chk("pre_hold_v", int'(a_v), 0);

        en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            #1;
            chk("hold_h", int'(a_h), 345);
            chk("hold_tick", int'(a_tick), 0);
        end
        en = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("resume_h", int'(a_h), 346);
        chk("b_first_frame_clk", b_first, 495);
        chk("c_first_frame_clk", c_first, 80);

        for (int i = 0; i < 2000; i++) begin
            if (a_v == 16'd1) break;
            @(negedge clk);
            #1;
        end
        chk("wrap_v", int'(a_v), 1);
        chk("wrap_h", int'(a_h), 0);
        chk("line_ticks", line_ticks, 800);
        chk("hsync_ticks", hs_cnt, 96);
        chk("hsync_first", hs_min, 656);
        chk("hsync_last", hs_max, 751);
        chk("video_ticks", vid_cnt, 640);

        for (int i = 0; i < 1500; i++) begin
            if (a_h == 16'd600) break;
            @(negedge clk);
            #1;
        end
        chk("pre_rst_h", int'(a_h), 600);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_h", int'(a_h), 0);
        chk("async_v", int'(a_v), 0);
        chk("async_hsync", int'(a_hs), 1);
        chk("async_vsync", int'(a_vs), 1);
        chk("async_video", int'(a_vid), 1);
        chk("async_fs", int'(a_fs), 0);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Short enable dropouts at varying divider phases.
        for (int i = 0; i < 1500; i++) begin
            en = ((i % 37) < 3) ? 1'b0 : 1'b1;
            @(negedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
